// File: rtl/sd_dat_block_rx.sv
// SD 4-bit DAT-line block receiver: start-bit hunt, nibble capture into a word buffer, per-line CRC16 and end-bit check.
// Optional CRC checking is built only when SD_DAT_RX_CRC_EN is defined; otherwise crc_err reads 0.
module sd_dat_block_rx #(
  parameter int BLOCK_BYTES     = 512,
  parameter int TIMEOUT_STROBES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sd_sample,
  input  logic [3:0]  dat_in,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        busy,
  output logic        irq
);

  localparam int WORDS = BLOCK_BYTES / 4;
  localparam int AW    = $clog2(WORDS);
  localparam int NW    = AW + 3;
  localparam int TW    = $clog2(TIMEOUT_STROBES + 1);
  localparam logic [NW-1:0] LAST_NIB  = NW'(2 * BLOCK_BYTES - 1);
  localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT_STROBES - 1);

  typedef enum logic [2:0] {IDLE, WAIT_START, DATA, CRC, END, DONE} state_t;

  state_t          state;
  logic            done;
  logic            crc_err;
  logic            end_err;
  logic            timeout;
  logic [15:0]     byte_cnt;
  logic [AW-1:0]   rd_ptr;
  logic [NW-1:0]   nib_cnt;
  logic [TW-1:0]   to_cnt;
  logic [3:0]      hi_nib;
  logic [23:0]     acc;
  logic [31:0]     mem [WORDS];

  logic            wr;
  logic            rd;
  logic            start_wr;
  logic            abort_wr;
  logic            arm;
  logic            buf_we;
  logic [AW-1:0]   buf_addr;
  logic [31:0]     buf_data;
  logic            unused_bits;

  assign wr       = chipselect & ~write_n;
  assign rd       = chipselect & read;
  assign start_wr = wr & (address == 2'd0) & writedata[0];
  assign abort_wr = wr & (address == 2'd0) & writedata[1];
  assign arm      = start_wr & ~abort_wr & ((state == IDLE) | (state == DONE));
  assign irq      = done;
  assign unused_bits = ^writedata;

  // A word is complete on the low nibble of its fourth byte; earlier bytes sit in acc, oldest lowest.
  assign buf_we   = sd_sample & (state == DATA) & (nib_cnt[2:0] == 3'b111);
  assign buf_addr = nib_cnt[NW-1:3];
  assign buf_data = {hi_nib, dat_in, acc};

  always_ff @(posedge clk) begin
    if (buf_we) mem[buf_addr] <= buf_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      end_err  <= 1'b0;
      timeout  <= 1'b0;
      byte_cnt <= '0;
      rd_ptr   <= '0;
      nib_cnt  <= '0;
      to_cnt   <= '0;
      hi_nib   <= '0;
      acc      <= '0;
    end else begin
      if (rd && address == 2'd1) rd_ptr <= rd_ptr + 1'b1;
      if (wr && address == 2'd2) rd_ptr <= writedata[AW-1:0];
      if (abort_wr) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else if (arm) begin
        state    <= WAIT_START;
        busy     <= 1'b1;
        done     <= 1'b0;
        end_err  <= 1'b0;
        timeout  <= 1'b0;
        byte_cnt <= '0;
        rd_ptr   <= '0;
        nib_cnt  <= '0;
        to_cnt   <= '0;
      end else if (sd_sample) begin
        case (state)
          WAIT_START: begin
            if (dat_in == 4'h0) begin
              state <= DATA;
            end else if (to_cnt == LAST_WAIT) begin
              timeout <= 1'b1;
              done    <= 1'b1;
              busy    <= 1'b0;
              state   <= DONE;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          DATA: begin
            if (!nib_cnt[0]) begin
              hi_nib <= dat_in;
            end else begin
              acc      <= {hi_nib, dat_in, acc[23:8]};
              byte_cnt <= byte_cnt + 1'b1;
            end
            if (nib_cnt == LAST_NIB) begin
              nib_cnt <= '0;
              state   <= CRC;
            end else begin
              nib_cnt <= nib_cnt + 1'b1;
            end
          end
          CRC: begin
            if (nib_cnt[3:0] == 4'hF) begin
              nib_cnt <= '0;
              state   <= END;
            end else begin
              nib_cnt <= nib_cnt + 1'b1;
            end
          end
          END: begin
            if (dat_in != 4'hF) end_err <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SD_DAT_RX_CRC_EN
  logic [15:0] crc [4];

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  // During CRC the computed value is shifted out MSB first and compared bit by bit with the line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_err <= 1'b0;
      for (int i = 0; i < 4; i++) crc[i] <= '0;
    end else if (!abort_wr) begin
      if (arm) begin
        crc_err <= 1'b0;
        for (int i = 0; i < 4; i++) crc[i] <= '0;
      end else if (sd_sample && state == DATA) begin
        for (int i = 0; i < 4; i++) crc[i] <= crc_step(crc[i], dat_in[i]);
      end else if (sd_sample && state == CRC) begin
        for (int i = 0; i < 4; i++) begin
          if (dat_in[i] != crc[i][15]) crc_err <= 1'b1;
          crc[i] <= {crc[i][14:0], 1'b0};
        end
      end
    end
  end
`else
  assign crc_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else if (rd) begin
      case (address)
        2'd0:    readdata <= {byte_cnt, 11'd0, timeout, end_err, crc_err, done, busy};
        2'd1:    readdata <= mem[rd_ptr];
        2'd2:    readdata <= {{(32-AW){1'b0}}, rd_ptr};
        default: readdata <= '0;
      endcase
    end
  end

endmodule
